// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//
// Shares the single CPU-side port of the memory controller between instruction
// fetch (IF) and the memory stage (DM). Each access is sequenced as
// grant -> issue -> wait for completion -> return data, and the pipeline stall
// signals are produced while a requester waits. DM is preferred because it
// belongs to the older instruction. A streak counter bounds how many DM grants
// may be made back to back while a fetch is pending, so IF always makes
// progress.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   if_req/if_addr    fetch read request (held until if_done) and its address
//   if_flush          drop the result of the in-flight fetch
//   if_rdata/if_valid fetched word and its one-cycle valid pulse
//   if_done           one-cycle pulse: fetch retired (valid or flushed)
//   dm_req/dm_we      data request (held until dm_done), 1 = write
//   dm_addr/dm_wdata  data address and write data
//   dm_rdata/dm_done  read data and one-cycle completion pulse
//   stall_if/stall_dm requester is waiting (req high, done not yet pulsed)
//   mem_op            to controller: 00 NOP, 01 READ, 10 WRITE
//   mem_addr/wdata    registered address / write data of current transaction
//   mem_ready         controller accepts the op this cycle
//   mem_tx_done       controller pulse: read or write complete
//   mem_rd_valid      controller pulse: mem_rdata valid
//   mem_rdata         controller read data

module mem_port_arbiter #(
    parameter int unsigned DATAW         = 32,
    parameter int unsigned ADDRW         = 32,
    parameter int unsigned MAX_DM_STREAK = 4
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             if_req,
    input  logic [ADDRW-1:0] if_addr,
    input  logic             if_flush,
    output logic [DATAW-1:0] if_rdata,
    output logic             if_valid,
    output logic             if_done,

    input  logic             dm_req,
    input  logic             dm_we,
    input  logic [ADDRW-1:0] dm_addr,
    input  logic [DATAW-1:0] dm_wdata,
    output logic [DATAW-1:0] dm_rdata,
    output logic             dm_done,

    output logic             stall_if,
    output logic             stall_dm,

    output logic [1:0]       mem_op,
    output logic [ADDRW-1:0] mem_addr,
    output logic [DATAW-1:0] mem_wdata,
    input  logic             mem_ready,
    input  logic             mem_tx_done,
    input  logic             mem_rd_valid,
    input  logic [DATAW-1:0] mem_rdata
);

    localparam int unsigned        StreakW   = $clog2(MAX_DM_STREAK + 1);
    localparam logic [StreakW-1:0] StreakMax = StreakW'(MAX_DM_STREAK);

    localparam logic [1:0] OpNop   = 2'b00;
    localparam logic [1:0] OpRead  = 2'b01;
    localparam logic [1:0] OpWrite = 2'b10;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWaitRd,
        StWaitWr
    } state_e;

    state_e             state;
    logic               owner_dm;       // 1 = current transaction belongs to DM
    logic               op_we;          // latched direction of current transaction
    logic               flush_pending;  // in-flight fetch result must be discarded
    logic [StreakW-1:0] streak;         // DM grants made while IF was waiting

    logic idle_free;
    logic streak_full;
    logic grant_dm;
    logic grant_if;

    // Grant decision. No grant is made in the cycle a done pulse is showing, so
    // requesters get that edge to drop or renew their request.
    always_comb begin
        idle_free   = (state == StIdle) && !if_done && !dm_done;
        streak_full = (streak == StreakMax);
        grant_dm    = idle_free && dm_req && !(if_req && streak_full);
        grant_if    = idle_free && !grant_dm && if_req;
    end

    always_comb begin
        stall_if = if_req && !if_done;
        stall_dm = dm_req && !dm_done;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= StIdle;
            owner_dm      <= 1'b0;
            op_we         <= 1'b0;
            flush_pending <= 1'b0;
            streak        <= '0;
            mem_op        <= OpNop;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            if_rdata      <= '0;
            dm_rdata      <= '0;
            if_valid      <= 1'b0;
            if_done       <= 1'b0;
            dm_done       <= 1'b0;
        end else begin
            // Completion flags are single-cycle pulses.
            if_valid <= 1'b0;
            if_done  <= 1'b0;
            dm_done  <= 1'b0;

            // Streak only moves on idle-cycle decisions; it saturates so the
            // next decision with IF pending is forced to IF.
            if (state == StIdle) begin
                if (!if_req || grant_if) begin
                    streak <= '0;
                end else if (grant_dm && !streak_full) begin
                    streak <= streak + 1'b1;
                end
            end

            // A flush only matters once the fetch has been granted; in IDLE the
            // fetch unit simply presents the new address.
            if (state != StIdle && !owner_dm && if_flush) begin
                flush_pending <= 1'b1;
            end

            case (state)
                StIdle: begin
                    if (grant_dm) begin
                        owner_dm  <= 1'b1;
                        op_we     <= dm_we;
                        mem_op    <= dm_we ? OpWrite : OpRead;
                        mem_addr  <= dm_addr;
                        mem_wdata <= dm_wdata;
                        state     <= StIssue;
                    end else if (grant_if) begin
                        owner_dm  <= 1'b0;
                        op_we     <= 1'b0;
                        mem_op    <= OpRead;
                        mem_addr  <= if_addr;
                        mem_wdata <= '0;
                        state     <= StIssue;
                    end
                end

                StIssue: begin
                    if (mem_ready) begin
                        mem_op <= OpNop;
                        state  <= op_we ? StWaitWr : StWaitRd;
                    end
                end

                // mem_tx_done is deliberately ignored here; only the data
                // strobe completes a read.
                StWaitRd: begin
                    if (mem_rd_valid) begin
                        if (owner_dm) begin
                            dm_rdata <= mem_rdata;
                            dm_done  <= 1'b1;
                        end else begin
                            if_rdata      <= mem_rdata;
                            if_done       <= 1'b1;
                            if_valid      <= !(flush_pending || if_flush);
                            flush_pending <= 1'b0;
                        end
                        state <= StIdle;
                    end
                end

                StWaitWr: begin
                    if (mem_tx_done) begin
                        dm_done <= 1'b1;
                        state   <= StIdle;
                    end
                end

                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single CPU-side port of the memory controller between instruction fetch (IF) and the memory stage (DM).
- Sequences each access as issue -> wait for completion -> return data, and produces the stall signals the pipeline needs while a requester waits.
- DM is preferred (older instruction); a streak limit guarantees IF forward progress.

Parameters:
- DATAW, 32, data word width
- ADDRW, 32, address width
- MAX_DM_STREAK, 4, consecutive DM grants allowed while IF is pending before IF must be granted (>=1)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- if_req  in  1  fetch read request; held until if_done
- if_addr  in  ADDRW  fetch address
- if_flush  in  1  discard result of the in-flight or pending fetch
- if_rdata  out  DATAW  fetched word; valid when if_valid
- if_valid  out  1  one-cycle pulse, fetch data valid
- if_done  out  1  one-cycle pulse, fetch transaction retired (valid or flushed)
- dm_req  in  1  data request; held until dm_done
- dm_we  in  1  1 = write, 0 = read
- dm_addr  in  ADDRW  data address
- dm_wdata  in  DATAW  write data
- dm_rdata  out  DATAW  read data; valid when dm_done on a read
- dm_done  out  1  one-cycle pulse, data transaction complete
- stall_if  out  1  high while if_req is high and if_done is low
- stall_dm  out  1  high while dm_req is high and dm_done is low
- mem_op  out  2  to memory controller: 00 NOP, 01 READ, 10 WRITE
- mem_addr  out  ADDRW  registered address of the current transaction
- mem_wdata  out  DATAW  registered write data
- mem_ready  in  1  controller can accept an op
- mem_tx_done  in  1  controller pulse: read or write complete
- mem_rd_valid  in  1  controller pulse: data on mem_rdata valid
- mem_rdata  in  DATAW  controller read data

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - state=IDLE, mem_op=00, mem_addr=0, mem_wdata=0.
  - if_valid=if_done=dm_done=0, if_rdata=dm_rdata=0.
  - streak counter=0, flush-pending=0.
  - Reset mid-transaction abandons it; no done pulse is emitted.
- States IDLE, ISSUE, WAIT_RD, WAIT_WR.
- IDLE, grant decision (combinational on registered state):
  - DM wins if dm_req and not (if_req and streak==MAX_DM_STREAK); otherwise IF if if_req; otherwise stay IDLE.
  - On grant: latch owner, op, addr and wdata into registers; go to ISSUE.
- ISSUE:
  - mem_op = latched op while mem_ready=0; hold in ISSUE.
  - First cycle with mem_ready=1: op accepted; next cycle mem_op=00.
  - Go to WAIT_RD for a read (IF always reads), WAIT_WR for a write.
- WAIT_RD, on mem_rd_valid=1:
  - Capture mem_rdata into the owner's rdata register.
  - Next cycle: pulse dm_done, or pulse if_done plus if_valid (if_valid suppressed if flushed).
  - Return to IDLE. mem_tx_done is ignored in WAIT_RD.
- WAIT_WR, on mem_tx_done=1: next cycle pulse dm_done; return to IDLE.
- Completion cycle: done pulse and IDLE coincide; a new grant is made no earlier than the cycle after the pulse, so requesters drop or renew req on the pulse edge.
- Minimum latency: req edge -> done pulse = 3 cycles (grant, issue with mem_ready=1, rd_valid/tx_done in the next cycle).
- Streak counter:
  - Increments on each DM grant made while if_req=1, saturating at MAX_DM_STREAK.
  - Clears on an IF grant, or in any IDLE cycle with if_req=0.
- if_flush:
  - While the owner is IF and not IDLE, sets flush-pending. The transaction still completes on the memory side; at completion if_done pulses, if_valid stays 0, and flush-pending clears.
  - In IDLE with if_req=1, the flush is ignored; the fetch is expected to present the new address.
- Simultaneous if_req and dm_req with streak<MAX: DM granted; IF stalled.
- Addresses and data are latched at grant; requester input changes after grant have no effect.
- dm_rdata and if_rdata hold their last captured value until overwritten.
- stall_if and stall_dm are combinational from req and the registered done flags.

Test Plan:
- Single fetch: if_req=1, if_addr=0x40, mem_ready=1, mem_rd_valid one cycle after issue with mem_rdata=0xDEADBEEF -> mem_op=01 for one cycle, mem_addr=0x40; if_rdata=0xDEADBEEF with if_valid=if_done=1 at cycle 3; stall_if=1 in cycles 0-2.
- DM write with backpressure: dm_we=1, dm_addr=0x100, dm_wdata=0x5, mem_ready low 3 cycles -> mem_op=10 held 4 cycles, then 00; dm_done one cycle after mem_tx_done; stall_dm high throughout.
- Contention: if_req and dm_req held continuously, MAX_DM_STREAK=4 -> grant order DM,DM,DM,DM,IF,DM...; IF never waits more than 4 DM transactions.
- Flush: if_flush pulsed while in WAIT_RD -> if_done=1 and if_valid=0 at completion; next fetch at the new address returns if_valid=1.
- Reset mid-op: rst=1 during WAIT_WR -> next cycle state IDLE, mem_op=00, no dm_done; a later dm_req is served normally.
- Read during WAIT_RD with stray mem_tx_done and no rd_valid -> no completion; completion occurs only on mem_rd_valid.
